display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, number of 7-segment digits scanned (legal range 1-8).
REQ-002 Parameter BIN_W, default 14, binary input width; 2^BIN_W-1 SHALL fit in N_DIGITS+1 BCD digits.
REQ-003 Parameter SCAN_DIV, default 1000, clk cycles per digit slot (legal range 2 or more).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 bin_in  input  BIN_W  unsigned binary value to display.
REQ-007 bin_valid  input  1  bin_in valid this cycle.
REQ-008 bin_ready  output  1  block can accept bin_in.
REQ-009 blank_lz  input  1  leading-zero blanking enable, sampled live.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active high.
REQ-011 dig_en  output  N_DIGITS  one-hot digit enable, active high, bit 0 = least significant digit.
REQ-012 busy  output  1  conversion in progress.
REQ-013 ovf  output  1  displayed value exceeds 10^N_DIGITS-1.

Function
REQ-014 FSM states IDLE, SHIFT and LOAD; bin_ready=1 only in IDLE; busy=1 in SHIFT and LOAD.
REQ-015 IDLE with bin_valid=1: accept bin_in into the shift register, clear the BCD register, set bit counter to BIN_W, latch ovf_pending = (bin_in > 10^N_DIGITS-1), go to SHIFT.
REQ-016 SHIFT, per cycle, double-dabble: add 3 to every BCD nibble of 5 or more, then shift {bcd,bin} left 1, decrement counter; after BIN_W SHIFT cycles go to LOAD.
REQ-017 LOAD: copy the low N_DIGITS BCD nibbles to the display register, ovf <= ovf_pending, go to IDLE; acceptance to display-register update SHALL take BIN_W+1 cycles, and bin_ready returns high the cycle after LOAD.
REQ-018 bin_valid while bin_ready=0 is ignored, with no queuing; the display register holds its value until the next LOAD.
REQ-019 Prescaler counts 0..SCAN_DIV-1 and wraps; on each wrap the digit index advances 0..N_DIGITS-1 and wraps to 0.
REQ-020 seg and dig_en are registered, reflecting the digit index and display register of the previous cycle (1-cycle latency).
REQ-021 dig_en = one-hot of the digit index.
REQ-022 Decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex); blank=00; dash=40.
REQ-023 ovf=1: seg shows dash on every digit, overriding value and blanking.
REQ-024 blank_lz=1: a digit with index > 0 is blank when it and all more-significant digits are zero; digit 0 is never blanked.
REQ-025 LOAD coinciding with a prescaler wrap: new index and new display value both take effect together at the next register update, with no mixed-digit output.

Reset
REQ-026 rst=1 at any clock edge, including mid-conversion, SHALL force IDLE, clear shift/BCD/display registers, counter, prescaler, digit index 0, ovf=0, seg=00, dig_en=0, bin_ready=1, busy=0.
REQ-027 An aborted conversion SHALL NOT update the display; after rst release the first registered output is dig_en=...0001 and seg=3F.

Verification (N_DIGITS=4, BIN_W=14, SCAN_DIV=4)
REQ-028 Reset for 2 cycles, then release -> next cycle dig_en=0001, seg=3F, bin_ready=1; every 4 cycles dig_en rotates 0010, 0100, 1000, 0001.
REQ-029 bin_in=1234 with one valid pulse -> bin_ready low exactly 15 cycles; then digit0 shows 66, digit1 4F, digit2 5B, digit3 06; ovf=0.
REQ-030 bin_in=7: with blank_lz=1, digits 3..1 show 00 and digit0 shows 07; toggle blank_lz=0 -> digits 3..1 show 3F. bin_in=0 with blank_lz=1 -> only digit0 shows 3F.
REQ-031 bin_in=9999 -> all digits 6F, ovf=0; bin_in=10000 -> ovf=1, all digits 40; then bin_in=5 -> ovf=0.
REQ-032 While busy, drive bin_valid with bin_in=4321 -> ignored, and the 1234 result displays; assert rst at cycle 8 of a conversion -> display cleared, showing 3F on all digits after release.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment display controller: binary-to-BCD double-dabble conversion
// feeding a display register that is scanned one digit per prescaler period.
module display_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic                bin_valid,
    output logic                bin_ready,
    input  logic                blank_lz,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] dig_en,
    output logic                busy,
    output logic                ovf,
    output logic [1:0]          fsm_state
);

    localparam int BCD_W   = 4 * (N_DIGITS + 1);
    localparam int CNT_W   = $clog2(BIN_W + 1);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [63:0] MAX_VAL = 64'(10 ** N_DIGITS) - 64'd1;

    // Handshake: bin_in is taken on a rising edge where bin_valid && bin_ready;
    // bin_valid while bin_ready is low is dropped, nothing is queued.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t             state;
    logic [BIN_W-1:0]   sh;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_pending;
    logic [3:0]         disp [N_DIGITS];

    logic [PRESC_W-1:0] presc;
    logic [IDX_W-1:0]   idx;
    logic [N_DIGITS:0]  zero_from;
    logic               blank_cur;
    logic [3:0]         cur_nib;
    logic [6:0]         seg_next;
    logic [N_DIGITS-1:0] dig_next;

    assign fsm_state = state;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < N_DIGITS + 1; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sh          <= '0;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            ovf         <= 1'b0;
            bin_ready   <= 1'b1;
            busy        <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                disp[i] <= 4'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bin_valid) begin
                        sh          <= bin_in;
                        bcd         <= '0;
                        cnt         <= CNT_W'(BIN_W);
                        ovf_pending <= (64'(bin_in) > MAX_VAL);
                        state       <= SHIFT;
                        bin_ready   <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    {bcd, sh} <= {bcd_adj[BCD_W-2:0], sh, 1'b0};
                    cnt       <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        disp[i] <= bcd[i*4 +: 4];
                    end
                    ovf       <= ovf_pending;
                    state     <= IDLE;
                    bin_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    bin_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // zero_from[i] is set when digit i and every more-significant digit are zero
    always_comb begin
        zero_from[N_DIGITS] = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (disp[i] == 4'd0);
        end
    end

    always_comb begin
        cur_nib   = disp[idx];
        blank_cur = blank_lz && (idx != '0) && zero_from[idx];
        seg_next  = 7'h00;
        if (ovf) begin
            seg_next = 7'h40;
        end else if (!blank_cur) begin
            case (cur_nib)
                4'd0: seg_next = 7'h3F;
                4'd1: seg_next = 7'h06;
                4'd2: seg_next = 7'h5B;
                4'd3: seg_next = 7'h4F;
                4'd4: seg_next = 7'h66;
                4'd5: seg_next = 7'h6D;
                4'd6: seg_next = 7'h7D;
                4'd7: seg_next = 7'h07;
                4'd8: seg_next = 7'h7F;
                4'd9: seg_next = 7'h6F;
                default: seg_next = 7'h00;
            endcase
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            dig_next[i] = (idx == IDX_W'(i));
        end
    end

    // Index and display register update on the same edge, so the output
    // register never combines a new index with an old value (or vice versa).
    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            idx    <= '0;
            seg    <= 7'h00;
            dig_en <= '0;
        end else begin
            if (presc == PRESC_W'(SCAN_DIV - 1)) begin
                presc <= '0;
                idx   <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            seg    <= seg_next;
            dig_en <= dig_next;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random values, all outputs
// compared every cycle against an arithmetic model of the displayed number.
module tb_display_scan_ctrl;

    localparam int N_DIGITS = 4;
    localparam int BIN_W    = 14;
    localparam int SCAN_DIV = 4;
    localparam int LATENCY  = BIN_W + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [BIN_W-1:0]    bin_in = '0;
    logic                bin_valid = 1'b0;
    logic                blank_lz = 1'b0;
    logic                bin_ready;
    logic [6:0]          seg;
    logic [N_DIGITS-1:0] dig_en;
    logic                busy;
    logic                ovf;
    logic [1:0]          fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    // model state: value on display, ovf, cycles left in a conversion
    int  m_edges, m_left, m_val, m_new, m_idx;
    bit  m_ovf;
    bit  chk_en = 1'b0;
    logic [6:0]          exp_seg;
    logic [N_DIGITS-1:0] exp_dig;
    bit  exp_ready, exp_busy, exp_ovf;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    display_scan_ctrl #(
        .N_DIGITS (N_DIGITS),
        .BIN_W    (BIN_W),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .bin_ready (bin_ready),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .dig_en    (dig_en),
        .busy      (busy),
        .ovf       (ovf),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(int val, bit ov, int idx, bit blz);
        int p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (ov) return 7'h40;
        if (blz && idx > 0 && val < p) return 7'h00;
        return seg_tab[(val / p) % 10];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_edges   = 0;
            m_left    = 0;
            m_val     = 0;
            m_ovf     = 1'b0;
            exp_seg   = 7'h00;
            exp_dig   = '0;
            exp_ready = 1'b1;
            exp_busy  = 1'b0;
            exp_ovf   = 1'b0;
            chk_en    = 1'b1;
        end else begin
            m_idx   = (m_edges / SCAN_DIV) % N_DIGITS;
            exp_dig = N_DIGITS'(1 << m_idx);
            exp_seg = seg_of(m_val, m_ovf, m_idx, blank_lz);
            m_edges++;
            if (m_left == 0) begin
                if (bin_valid) begin
                    m_left = LATENCY;
                    m_new  = int'(bin_in);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_val = m_new;
                    m_ovf = (m_new > 9999);
                end
            end
            exp_ready = (m_left == 0);
            exp_busy  = (m_left != 0);
            exp_ovf   = m_ovf;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("seg", 32'(seg), 32'(exp_seg));
            check("dig_en", 32'(dig_en), 32'(exp_dig));
            check("bin_ready", 32'(bin_ready), 32'(exp_ready));
            check("busy", 32'(busy), 32'(exp_busy));
            check("ovf", 32'(ovf), 32'(exp_ovf));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int v);
        bin_in    = BIN_W'(v);
        bin_valid = 1'b1;
        @(negedge clk);
        bin_valid = 1'b0;
    endtask

    task automatic reset_pulse(input int n);
        rst = 1'b1;
        cycles(n);
        rst = 1'b0;
    endtask

    initial begin
        int v;
        int sel;
        cycles(2);
        rst = 1'b0;
        cycles(20);

        send(1234);
        cycles(40);

        blank_lz = 1'b1;
        send(7);
        cycles(36);
        blank_lz = 1'b0;
        cycles(20);
        blank_lz = 1'b1;
        send(0);
        cycles(36);
        blank_lz = 1'b0;

        send(9999);
        cycles(36);
        send(10000);
        cycles(36);
        send(5);
        cycles(36);

        send(1234);
        cycles(4);
        send(4321);
        cycles(36);

        send(1111);
        cycles(30);
        send(1234);
        cycles(6);
        reset_pulse(2);
        cycles(24);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: v = 0;
                1: v = 9999;
                2: v = 10000;
                3: v = (1 << BIN_W) - 1;
                default: v = $urandom_range(0, (1 << BIN_W) - 1);
            endcase
            blank_lz = 1'($urandom_range(0, 1));
            send(v);
            cycles($urandom_range(1, 40));
            if ($urandom_range(0, 7) == 0) begin
                reset_pulse($urandom_range(1, 3));
            end
        end
        cycles(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
